uart_io_bridge: RTL and testbench

- Serial I/O front end of the basic computer. It converts an external UART line into the 16-bit word that feeds the CPU input register, and serialises words written to the output register back onto a UART line.
- Uses FGI/FGO flag handshakes so the CPU's input/output instructions can poll and consume data.
- Each 16-bit word travels as two UART bytes, low byte first.

---
 rtl/uart_io_bridge.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_uart_io_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_bridge.sv
// uart_io_bridge: serial I/O front end of the basic computer.
// Receives UART bytes into 16-bit words for the CPU input register (FGI handshake)
// and serialises words from the CPU output register onto a UART line (FGO handshake).
// Each word travels as two frames, low byte first.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   rx / tx               serial lines, both idle high (rx is asynchronous to clk)
//   inpr_data, fgi        last complete received word and its "new word" flag
//   fgi_clr               CPU consumed inpr_data
//   outr_data, outr_load  word to transmit and its load strobe
//   fgo                   transmitter idle, ready for outr_load
//   rx_overrun, frame_err, parity_err  sticky error bits, cleared by err_clr
//
// Build option: define UART_IO_PARITY_EN for 8E1 frames; default is 8N1
// with parity_err tied to 0.
module uart_io_bridge #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic [15:0] inpr_data,
    output logic        fgi,
    input  logic        fgi_clr,
    input  logic [15:0] outr_data,
    input  logic        outr_load,
    output logic        fgo,
    output logic        rx_overrun,
    output logic        frame_err,
    output logic        parity_err,
    input  logic        err_clr
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_IO_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic [2:0]       r_rx_state;
    logic [2:0]       w_rx_next;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_low;
    logic             r_rx_phase;     // 0 = expecting low byte, 1 = high byte
    logic [15:0]      r_inpr;
    logic             r_fgi;
    logic             r_overrun;
    logic             r_frame_err;

    logic w_rx_fall;
    logic w_rx_tick;
    logic w_rx_half;
    logic w_rx_restart;
    logic w_stop_sample;
    logic w_frame_bad;
    logic w_par_bad;
    logic w_byte_ok;
    logic w_word_done;

    assign w_rx_fall     = r_rx_prev & ~r_rx_sync;
    assign w_rx_tick     = (r_rx_cnt == BIT_END);
    assign w_rx_half     = (r_rx_cnt == HALF_END);
    assign w_stop_sample = (r_rx_state == S_STOP) & w_rx_tick;
    assign w_frame_bad   = w_stop_sample & ~r_rx_sync;

`ifdef UART_IO_PARITY_EN
    logic r_rx_par;
    logic r_parity_err;
    // Parity is only judged on frames with a good stop bit, so frame errors win.
    assign w_par_bad = w_stop_sample & r_rx_sync & (^{r_rx_shift, r_rx_par});
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_byte_ok   = w_stop_sample & r_rx_sync & ~w_par_bad;
    assign w_word_done = w_byte_ok & r_rx_phase;

    // RX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rx_state <= S_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    // RX next-state logic
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
            S_START: if (w_rx_half) w_rx_next = r_rx_sync ? S_IDLE : S_DATA;
`ifdef UART_IO_PARITY_EN
            S_DATA:   if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_PARITY;
            S_PARITY: if (w_rx_tick) w_rx_next = S_STOP;
`else
            S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_STOP;
`endif
            S_STOP:  if (w_rx_tick) w_rx_next = S_IDLE;
            default: w_rx_next = S_IDLE;
        endcase
    end

    // Bit timer restarts on every state change and on each data-bit sample.
    assign w_rx_restart = (w_rx_next != r_rx_state) | ((r_rx_state == S_DATA) & w_rx_tick);

    // RX synchroniser, bit timer, shifter and byte phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_low   <= '0;
            r_rx_phase <= 1'b0;
`ifdef UART_IO_PARITY_EN
            r_rx_par   <= 1'b0;
`endif
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;

            if (r_rx_state == S_IDLE || w_rx_restart) r_rx_cnt <= '0;
            else                                      r_rx_cnt <= r_rx_cnt + 1'b1;

            if (r_rx_state == S_START) r_rx_bit <= '0;
            if (r_rx_state == S_DATA && w_rx_tick) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
`ifdef UART_IO_PARITY_EN
            if (r_rx_state == S_PARITY && w_rx_tick) r_rx_par <= r_rx_sync;
`endif
            if (w_stop_sample) begin
                if (!w_byte_ok) begin
                    r_rx_phase <= 1'b0;
                end else if (!r_rx_phase) begin
                    r_rx_low   <= r_rx_shift;
                    r_rx_phase <= 1'b1;
                end else begin
                    r_rx_phase <= 1'b0;
                end
            end
        end
    end

    // Input register, FGI flag and sticky errors; a completing word beats fgi_clr,
    // and a new error beats err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inpr      <= '0;
            r_fgi       <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_IO_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_word_done && (!r_fgi || fgi_clr)) begin
                r_inpr <= {r_rx_shift, r_rx_low};
                r_fgi  <= 1'b1;
            end else if (fgi_clr) begin
                r_fgi  <= 1'b0;
            end

            if (err_clr) begin
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
`ifdef UART_IO_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end
            if (w_word_done && r_fgi && !fgi_clr) r_overrun <= 1'b1;
            if (w_frame_bad) r_frame_err <= 1'b1;
`ifdef UART_IO_PARITY_EN
            if (w_par_bad) r_parity_err <= 1'b1;
`endif
        end
    end

    assign inpr_data  = r_inpr;
    assign fgi        = r_fgi;
    assign rx_overrun = r_overrun;
    assign frame_err  = r_frame_err;
`ifdef UART_IO_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    logic [2:0]       r_tx_state;
    logic [2:0]       w_tx_next;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic             r_tx_byte;      // 0 = low byte frame, 1 = high byte frame
    logic [15:0]      r_tx_word;
    logic             r_tx;
    logic             r_fgo;

    logic       w_tx_tick;
    logic [7:0] w_tx_cur;

    assign w_tx_tick = (r_tx_cnt == BIT_END);
    assign w_tx_cur  = r_tx_byte ? r_tx_word[15:8] : r_tx_word[7:0];

    // TX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tx_state <= S_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    // TX next-state logic; the high byte frame follows the low one with no gap
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (outr_load && r_fgo) w_tx_next = S_START;
            S_START: if (w_tx_tick) w_tx_next = S_DATA;
`ifdef UART_IO_PARITY_EN
            S_DATA:   if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_PARITY;
            S_PARITY: if (w_tx_tick) w_tx_next = S_STOP;
`else
            S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
`endif
            S_STOP:  if (w_tx_tick) w_tx_next = r_tx_byte ? S_IDLE : S_START;
            default: w_tx_next = S_IDLE;
        endcase
    end

    // TX bit timer, line driver and FGO; tx always carries the bit of the current state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_byte <= 1'b0;
            r_tx_word <= '0;
            r_tx      <= 1'b1;
            r_fgo     <= 1'b1;
        end else begin
            if (r_tx_state == S_IDLE || w_tx_tick) r_tx_cnt <= '0;
            else                                   r_tx_cnt <= r_tx_cnt + 1'b1;

            case (r_tx_state)
                S_IDLE: begin
                    if (outr_load && r_fgo) begin
                        r_tx_word <= outr_data;
                        r_tx_byte <= 1'b0;
                        r_fgo     <= 1'b0;
                        r_tx      <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tx_tick) begin
                        r_tx     <= w_tx_cur[0];
                        r_tx_bit <= '0;
                    end
                end
                S_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_bit <= r_tx_bit + 3'd1;
                        if (r_tx_bit == 3'd7) begin
`ifdef UART_IO_PARITY_EN
                            r_tx <= ^w_tx_cur;
`else
                            r_tx <= 1'b1;
`endif
                        end else begin
                            r_tx <= w_tx_cur[r_tx_bit + 3'd1];
                        end
                    end
                end
`ifdef UART_IO_PARITY_EN
                S_PARITY: begin
                    if (w_tx_tick) r_tx <= 1'b1;
                end
`endif
                S_STOP: begin
                    if (w_tx_tick) begin
                        if (!r_tx_byte) begin
                            r_tx_byte <= 1'b1;
                            r_tx      <= 1'b0;
                        end else begin
                            r_fgo <= 1'b1;
                            r_tx  <= 1'b1;
                        end
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign tx  = r_tx;
    assign fgo = r_fgo;

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed testbench for uart_io_bridge at 16 clocks per bit.
// Honours UART_IO_PARITY_EN so the same bench covers both frame formats.
module tb_uart_io_bridge;

    localparam int CPB = 16;
`ifdef UART_IO_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    // Negedge index (within the second byte) just before the completing stop sample
    localparam int DONE_M = CPB * (FB - 1) + CPB / 2 + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        tx;
    logic [15:0] inpr_data;
    logic        fgi;
    logic        fgi_clr;
    logic [15:0] outr_data;
    logic        outr_load;
    logic        fgo;
    logic        rx_overrun;
    logic        frame_err;
    logic        parity_err;
    logic        err_clr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_io_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx),
        .inpr_data(inpr_data), .fgi(fgi), .fgi_clr(fgi_clr),
        .outr_data(outr_data), .outr_load(outr_load), .fgo(fgo),
        .rx_overrun(rx_overrun), .frame_err(frame_err), .parity_err(parity_err),
        .err_clr(err_clr)
    );

    // Drive one frame on rx; samples fgi around the stop-sample edge and can pulse fgi_clr on it.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_good,
                             input logic do_clr, output logic fgi_pre, output logic fgi_post);
        logic [FB-1:0] bits;
        int m;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_IO_PARITY_EN
        bits[9] = par_good ? ^b : ~^b;
`endif
        bits[FB-1] = stop_bit;
        m = 0;
        fgi_pre = 1'bx;
        fgi_post = 1'bx;
        for (int k = 0; k < FB; k++) begin
            rx = bits[k];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                m++;
                if (m == DONE_M) fgi_pre = fgi;
                if (m == DONE_M + 1) fgi_post = fgi;
                fgi_clr = (do_clr && m == DONE_M) ? 1'b1 : 1'b0;
            end
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic do_clr,
                             output logic fgi_pre, output logic fgi_post);
        logic a, b;
        send_byte(w[7:0], 1'b1, 1'b1, 1'b0, a, b);
        send_byte(w[15:8], 1'b1, 1'b1, do_clr, fgi_pre, fgi_post);
    endtask

    task automatic pulse_fgi_clr();
        fgi_clr = 1'b1;
        @(negedge clk);
        fgi_clr = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; fgi_clr = 1'b0; outr_load = 1'b0; outr_data = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b exp 1", tx); else n_pass++;
        n_total++; if (fgo !== 1'b1) $display("FAIL reset_fgo: got %b exp 1", fgo); else n_pass++;
        n_total++; if (fgi !== 1'b0) $display("FAIL reset_fgi: got %b exp 0", fgi); else n_pass++;
        n_total++; if (inpr_data !== 16'h0000) $display("FAIL reset_inpr: got %h exp 0000", inpr_data); else n_pass++;
        n_total++; if ({rx_overrun, frame_err, parity_err} !== 3'b000)
            $display("FAIL reset_errs: got %b exp 000", {rx_overrun, frame_err, parity_err}); else n_pass++;
    endtask

    task automatic test_rx_word();
        logic a, b, pre, post;
        send_byte(8'hEF, 1'b1, 1'b1, 1'b0, a, b);
        n_total++; if (fgi !== 1'b0) $display("FAIL rx_half_fgi: got %b exp 0", fgi); else n_pass++;
        send_byte(8'hBE, 1'b1, 1'b1, 1'b0, pre, post);
        n_total++; if (pre !== 1'b0) $display("FAIL rx_fgi_before_stop: got %b exp 0", pre); else n_pass++;
        n_total++; if (post !== 1'b1) $display("FAIL rx_fgi_after_stop: got %b exp 1", post); else n_pass++;
        n_total++; if (inpr_data !== 16'hBEEF) $display("FAIL rx_word_data: got %h exp BEEF", inpr_data); else n_pass++;
        n_total++; if ({rx_overrun, frame_err, parity_err} !== 3'b000)
            $display("FAIL rx_word_errs: got %b exp 000", {rx_overrun, frame_err, parity_err}); else n_pass++;
    endtask

    task automatic test_tx(input logic [15:0] w);
        logic [2*FB-1:0] exp_bits;
        logic [2*FB-1:0] got_bits;
        logic [7:0] byt;
        int busy;
        for (int n = 0; n < 2; n++) begin
            byt = (n == 0) ? w[7:0] : w[15:8];
            exp_bits[n*FB] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[n*FB+1+i] = byt[i];
`ifdef UART_IO_PARITY_EN
            exp_bits[n*FB+9] = ^byt;
`endif
            exp_bits[n*FB+FB-1] = 1'b1;
        end
        got_bits = '0;
        busy = 0;
        outr_data = w; outr_load = 1'b1;
        @(negedge clk);
        outr_load = 1'b0;
        for (int j = 0; j < 2*FB*CPB + 30; j++) begin
            if (fgo === 1'b0) busy++;
            if ((j % CPB) == CPB/2 && (j / CPB) < 2*FB) got_bits[j/CPB] = tx;
            if (j == 100) begin
                outr_data = 16'hFFFF; outr_load = 1'b1;
            end else if (j == 101) begin
                outr_load = 1'b0; outr_data = w;
            end
            @(negedge clk);
        end
        n_total++; if (got_bits !== exp_bits) $display("FAIL tx_bits: got %b exp %b", got_bits, exp_bits); else n_pass++;
        n_total++; if (busy !== 2*FB*CPB) $display("FAIL tx_busy_cycles: got %0d exp %0d", busy, 2*FB*CPB); else n_pass++;
        n_total++; if (fgo !== 1'b1) $display("FAIL tx_fgo_end: got %b exp 1", fgo); else n_pass++;
        n_total++; if (tx !== 1'b1) $display("FAIL tx_idle_end: got %b exp 1", tx); else n_pass++;
    endtask

    task automatic test_overrun();
        logic pre, post;
        pulse_fgi_clr();
        n_total++; if (fgi !== 1'b0) $display("FAIL ovr_fgi_clr: got %b exp 0", fgi); else n_pass++;
        send_word(16'h0001, 1'b0, pre, post);
        n_total++; if (inpr_data !== 16'h0001) $display("FAIL ovr_first: got %h exp 0001", inpr_data); else n_pass++;
        send_word(16'h0002, 1'b0, pre, post);
        n_total++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag: got %b exp 1", rx_overrun); else n_pass++;
        n_total++; if (inpr_data !== 16'h0001) $display("FAIL ovr_kept: got %h exp 0001", inpr_data); else n_pass++;
        pulse_err_clr();
        n_total++; if (rx_overrun !== 1'b0) $display("FAIL ovr_err_clr: got %b exp 0", rx_overrun); else n_pass++;
        send_word(16'h0002, 1'b1, pre, post);
        n_total++; if (inpr_data !== 16'h0002) $display("FAIL ovr_clr_same_cycle_data: got %h exp 0002", inpr_data); else n_pass++;
        n_total++; if (fgi !== 1'b1) $display("FAIL ovr_clr_same_cycle_fgi: got %b exp 1", fgi); else n_pass++;
        n_total++; if (rx_overrun !== 1'b0) $display("FAIL ovr_clr_same_cycle_ovr: got %b exp 0", rx_overrun); else n_pass++;
    endtask

    task automatic test_frame_err();
        logic a, b;
        pulse_fgi_clr();
        send_byte(8'h99, 1'b1, 1'b1, 1'b0, a, b);
        send_byte(8'h55, 1'b0, 1'b1, 1'b0, a, b);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        n_total++; if (frame_err !== 1'b1) $display("FAIL frm_flag: got %b exp 1", frame_err); else n_pass++;
        n_total++; if (fgi !== 1'b0) $display("FAIL frm_no_word: got %b exp 0", fgi); else n_pass++;
        send_word(16'h2211, 1'b0, a, b);
        n_total++; if (inpr_data !== 16'h2211) $display("FAIL frm_phase_reset: got %h exp 2211", inpr_data); else n_pass++;
        n_total++; if (fgi !== 1'b1) $display("FAIL frm_after_fgi: got %b exp 1", fgi); else n_pass++;
        pulse_err_clr();
        n_total++; if (frame_err !== 1'b0) $display("FAIL frm_err_clr: got %b exp 0", frame_err); else n_pass++;
    endtask

    task automatic test_glitch();
        logic a, b;
        pulse_fgi_clr();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        n_total++; if (fgi !== 1'b0) $display("FAIL glitch_fgi: got %b exp 0", fgi); else n_pass++;
        n_total++; if ({rx_overrun, frame_err, parity_err} !== 3'b000)
            $display("FAIL glitch_errs: got %b exp 000", {rx_overrun, frame_err, parity_err}); else n_pass++;
        send_word(16'hA55A, 1'b0, a, b);
        n_total++; if (inpr_data !== 16'hA55A) $display("FAIL glitch_recover: got %h exp A55A", inpr_data); else n_pass++;
    endtask

`ifdef UART_IO_PARITY_EN
    task automatic test_parity();
        logic a, b;
        pulse_fgi_clr();
        send_byte(8'h33, 1'b1, 1'b1, 1'b0, a, b);
        send_byte(8'h07, 1'b1, 1'b0, 1'b0, a, b);
        n_total++; if (parity_err !== 1'b1) $display("FAIL par_flag: got %b exp 1", parity_err); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL par_no_frame: got %b exp 0", frame_err); else n_pass++;
        n_total++; if (fgi !== 1'b0) $display("FAIL par_dropped: got %b exp 0", fgi); else n_pass++;
        send_word(16'h6611, 1'b0, a, b);
        n_total++; if (inpr_data !== 16'h6611) $display("FAIL par_phase_reset: got %h exp 6611", inpr_data); else n_pass++;
        pulse_err_clr();
        n_total++; if (parity_err !== 1'b0) $display("FAIL par_err_clr: got %b exp 0", parity_err); else n_pass++;
        test_tx(16'h0003);
    endtask
`endif

    task automatic test_reset_mid_tx();
        outr_data = 16'hA5A5; outr_load = 1'b1;
        @(negedge clk);
        outr_load = 1'b0;
        repeat (8) @(negedge clk);
        n_total++; if (tx !== 1'b0) $display("FAIL rst_pre_tx: got %b exp 0", tx); else n_pass++;
        n_total++; if (fgo !== 1'b0) $display("FAIL rst_pre_fgo: got %b exp 0", fgo); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (tx !== 1'b1) $display("FAIL rst_mid_tx: got %b exp 1", tx); else n_pass++;
        n_total++; if (fgo !== 1'b1) $display("FAIL rst_mid_fgo: got %b exp 1", fgo); else n_pass++;
        n_total++; if (fgi !== 1'b0 || inpr_data !== 16'h0000)
            $display("FAIL rst_mid_rx: got fgi=%b inpr=%h exp 0/0000", fgi, inpr_data); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        n_total++; if (tx !== 1'b1 || fgo !== 1'b1)
            $display("FAIL rst_after: got tx=%b fgo=%b exp 1/1", tx, fgo); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rx_word();
        test_tx(16'h1234);
        test_overrun();
        test_frame_err();
        test_glitch();
`ifdef UART_IO_PARITY_EN
        test_parity();
`endif
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
